// File: rtl/pll27_pkg.sv
// pll27_pkg
//   Shared definitions for logic that consumes the pll27 PLL outputs.
//   - seq_state_t       : lock/reset sequencer states (encoding is visible on
//                         the debug port, so the values are fixed)
//   - PLL27_*_CYCLES    : default qualification and reset-hold lengths
//   - seq_cnt_bits()    : width of a counter that must reach max(a,b)-1
package pll27_pkg;

    typedef enum logic [1:0] {
        SEQ_WAIT_LOCK = 2'd0,
        SEQ_STABILIZE = 2'd1,
        SEQ_HOLD      = 2'd2,
        SEQ_RUN       = 2'd3
    } seq_state_t;

    localparam int PLL27_LOCK_CYCLES = 1024;
    localparam int PLL27_HOLD_CYCLES = 16;

    // A single counter is shared by STABILIZE and HOLD, so it has to cover
    // the longer of the two phases. At least one bit even for 1-cycle phases.
    function automatic int seq_cnt_bits(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2
//   Generic two-flop bit synchronizer with asynchronous active-low clear.
//   Output q follows input d two clk edges later.
// Ports
//   clk    in  1  destination clock
//   rst_n  in  1  asynchronous active-low clear (both flops to 0)
//   d      in  1  asynchronous input bit
//   q      out 1  synchronized bit (second flop)
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq
//   Qualifies the pll27 LOCK indication and produces the synchronous
//   active-low system reset for the clkout0 domain. Downstream logic is held
//   in reset until lock has been stable for LOCK_CYCLES cycles plus a
//   HOLD_CYCLES reset pulse; loss of lock re-enters reset and is counted.
//
//   State flow: WAIT_LOCK -> STABILIZE -> HOLD -> RUN. Any lock_s=0 returns
//   to WAIT_LOCK. In RUN, sw_reset_req re-runs HOLD (lock loss wins when both
//   occur together).
//
//   Handshake: none. sw_reset_req is a single-cycle strobe sampled only in
//   RUN; there is no acknowledge. pll_lock is a level, synchronized here.
// Ports
//   clk              in  1      PLL clkout0, sole clock
//   rst_n            in  1      asynchronous active-low reset (board reset)
//   pll_lock         in  1      raw PLL lock, asynchronous to clk
//   sw_reset_req     in  1      one-cycle request to re-run HOLD while in RUN
//   sys_rst_n        out 1      registered system reset, high only in RUN
//   lock_stable      out 1      registered, high only in RUN
//   lost_lock_count  out CNT_W  saturating count of RUN->WAIT_LOCK exits
//   seq_state        out 2      current state (debug)
module pll_lock_reset_seq
    import pll27_pkg::*;
#(
    parameter int LOCK_CYCLES = PLL27_LOCK_CYCLES,
    parameter int HOLD_CYCLES = PLL27_HOLD_CYCLES,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             sw_reset_req,
    output logic             sys_rst_n,
    output logic             lock_stable,
    output logic [CNT_W-1:0] lost_lock_count,
    output logic [1:0]       seq_state
);

    localparam int CW = seq_cnt_bits(LOCK_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    logic          lock_s;
    seq_state_t    state;
    logic [CW-1:0] cnt;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // sys_rst_n and lock_stable are loaded with (next state == RUN), so they
    // change on the same edge as state and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= SEQ_WAIT_LOCK;
            cnt             <= '0;
            sys_rst_n       <= 1'b0;
            lock_stable     <= 1'b0;
            lost_lock_count <= '0;
        end else begin
            case (state)
                SEQ_WAIT_LOCK: begin
                    cnt         <= '0;
                    sys_rst_n   <= 1'b0;
                    lock_stable <= 1'b0;
                    if (lock_s) begin
                        state <= SEQ_STABILIZE;
                    end
                end

                SEQ_STABILIZE: begin
                    sys_rst_n   <= 1'b0;
                    lock_stable <= 1'b0;
                    if (!lock_s) begin
                        // A glitch restarts qualification from scratch.
                        state <= SEQ_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state <= SEQ_HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                SEQ_HOLD: begin
                    if (!lock_s) begin
                        // Not yet in RUN, so this is not a counted lock loss.
                        state       <= SEQ_WAIT_LOCK;
                        cnt         <= '0;
                        sys_rst_n   <= 1'b0;
                        lock_stable <= 1'b0;
                    end else if (cnt == HOLD_LAST) begin
                        state       <= SEQ_RUN;
                        cnt         <= '0;
                        sys_rst_n   <= 1'b1;
                        lock_stable <= 1'b1;
                    end else begin
                        cnt         <= cnt + CW'(1);
                        sys_rst_n   <= 1'b0;
                        lock_stable <= 1'b0;
                    end
                end

                SEQ_RUN: begin
                    cnt <= '0;
                    if (!lock_s) begin
                        state       <= SEQ_WAIT_LOCK;
                        sys_rst_n   <= 1'b0;
                        lock_stable <= 1'b0;
                        if (lost_lock_count != '1) begin
                            lost_lock_count <= lost_lock_count + CNT_W'(1);
                        end
                    end else if (sw_reset_req) begin
                        state       <= SEQ_HOLD;
                        sys_rst_n   <= 1'b0;
                        lock_stable <= 1'b0;
                    end else begin
                        sys_rst_n   <= 1'b1;
                        lock_stable <= 1'b1;
                    end
                end

                default: begin
                    state       <= SEQ_WAIT_LOCK;
                    cnt         <= '0;
                    sys_rst_n   <= 1'b0;
                    lock_stable <= 1'b0;
                end
            endcase
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq
//   Bench for pll_lock_reset_seq with LOCK_CYCLES=8, HOLD_CYCLES=4, CNT_W=2.
//   The reference model tracks a "release deadline": the edge at which the
//   sequencer is due to reach RUN if lock stays good. Lock loss cancels it,
//   a fresh lock sets it LOCK+HOLD edges out, a software request in RUN sets
//   it HOLD edges out. Phase and outputs are derived from that deadline.
module tb_pll_lock_reset_seq;

    localparam int L  = 8;
    localparam int H  = 4;
    localparam int CW = 2;
    localparam int LOST_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_lock = 1'b0;
    logic          sw_reset_req = 1'b0;
    logic          sys_rst_n;
    logic          lock_stable;
    logic [CW-1:0] lost_lock_count;
    logic [1:0]    seq_state;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int cyc;
    int dl;
    bit dl_valid;
    bit m_s0, m_s1;
    int lost_m;

    pll_lock_reset_seq #(
        .LOCK_CYCLES (L),
        .HOLD_CYCLES (H),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_lock        (pll_lock),
        .sw_reset_req    (sw_reset_req),
        .sys_rst_n       (sys_rst_n),
        .lock_stable     (lock_stable),
        .lost_lock_count (lost_lock_count),
        .seq_state       (seq_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        cyc      = 0;
        dl       = 0;
        dl_valid = 1'b0;
        m_s0     = 1'b0;
        m_s1     = 1'b0;
        lost_m   = 0;
    endtask

    function automatic int exp_state();
        if (!dl_valid)         return 0;
        else if (cyc >= dl)    return 3;
        else if (cyc >= dl - H) return 2;
        else                   return 1;
    endfunction

    task automatic model_edge(input bit lk, input bit sw);
        bit run_pre;
        cyc++;
        run_pre = dl_valid && ((cyc - 1) >= dl);
        if (!m_s1) begin
            if (run_pre && lost_m < LOST_MAX) lost_m++;
            dl_valid = 1'b0;
        end else if (!dl_valid) begin
            dl_valid = 1'b1;
            dl       = cyc + L + H;
        end else if (run_pre && sw) begin
            dl = cyc + H;
        end
        m_s1 = m_s0;
        m_s0 = lk;
    endtask

    // ---------------- drivers ----------------
    // Drive inputs at the falling edge, clock one rising edge, compare at the
    // next falling edge.
    task automatic step(input bit lk, input bit sw);
        int es;
        pll_lock     = lk;
        sw_reset_req = sw;
        @(posedge clk);
        model_edge(lk, sw);
        @(negedge clk);
        es = exp_state();
        check("seq_state",       32'(seq_state),       32'(es));
        check("sys_rst_n",       32'(sys_rst_n),       32'(es == 3));
        check("lock_stable",     32'(lock_stable),     32'(es == 3));
        check("lost_lock_count", 32'(lost_lock_count), 32'(lost_m));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sys_rst_n"}, 32'(sys_rst_n),       32'd0);
        check({tag, "_stable"},    32'(lock_stable),     32'd0);
        check({tag, "_lost"},      32'(lost_lock_count), 32'd0);
        check({tag, "_state"},     32'(seq_state),       32'd0);
    endtask

    task automatic do_reset(input bit lk);
        rst_n        = 1'b0;
        pll_lock     = lk;
        sw_reset_req = 1'b0;
        repeat (5) @(negedge clk);
        model_reset();
        check_reset_outputs("reset");
        rst_n = 1'b1;
    endtask

    // Step until sys_rst_n reaches lvl; n = edges taken (200 = timed out).
    task automatic wait_level(input bit lvl, input bit lk, output int n);
        n = 0;
        do begin
            step(lk, 1'b0);
            n++;
        end while (sys_rst_n !== lvl && n < 200);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;

        // 1: power-up with lock already high
        do_reset(1'b1);
        wait_level(1'b1, 1'b1, n);
        check("t1_release_latency", 32'(n), 32'(2 + 1 + L + H));
        check("t1_lock_stable", 32'(lock_stable), 32'd1);

        // 2: one-cycle lock glitch while qualifying
        do_reset(1'b1);
        repeat (7) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        wait_level(1'b1, 1'b1, n);
        check("t2_requal_latency", 32'(n), 32'(2 + 1 + L + H));
        check("t2_lost", 32'(lost_lock_count), 32'd0);

        // 3: lock loss in RUN, then recovery
        wait_level(1'b0, 1'b0, n);
        check("t3_loss_latency", 32'(n), 32'd3);
        check("t3_lost", 32'(lost_lock_count), 32'd1);
        wait_level(1'b1, 1'b1, n);
        check("t3_recover_latency", 32'(n), 32'(2 + 1 + L + H));

        // 4: software reset request in RUN
        step(1'b1, 1'b1);
        check("t4_rst_low", 32'(sys_rst_n), 32'd0);
        wait_level(1'b1, 1'b1, n);
        check("t4_low_cycles", 32'(n), 32'(H));
        check("t4_lost", 32'(lost_lock_count), 32'd1);

        // 5: lock loss and sw request together, repeated to saturation
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            check("t5_state_wait", 32'(seq_state), 32'd0);
            wait_level(1'b1, 1'b1, n);
            check("t5_rerun", 32'(n), 32'(2 + 1 + L + H));
        end
        check("t5_saturated", 32'(lost_lock_count), 32'(LOST_MAX));

        // 6: asynchronous reset in the middle of HOLD
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("t6_in_hold", 32'(seq_state), 32'd2);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_async");
        do_reset(1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) begin
                do_reset(1'($urandom_range(0, 1)));
            end
            step(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
